// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types and sizes for the main-memory refill arbiter.
// Used by mem_refill_arbiter and rr_pick2.
package mem_arb_pkg;

    localparam int BLOCK_W     = 128;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        SRC_IC = 2'd0,
        SRC_DC = 2'd1,
        SRC_WB = 2'd2
    } arb_src_e;

endpackage

// File: rtl/mem_refill_arbiter_rr_pick2.sv
// Two-way round-robin selector: i_ptr names the requester that wins a tie
// (0 = bit 0, 1 = bit 1). The grant output is one-hot, or zero when no request is present.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    // pass a lone request straight through; break a tie with the pointer
    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt = i_ptr ? 2'b10 : 2'b01;
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one 128-bit memory port between I-cache refill, D-cache refill and
// D-cache writeback. Optional perf counters are enabled by the ARB_PERF_CNT_EN macro.
module mem_refill_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_W     = mem_arb_pkg::BLOCK_W,
    parameter int OFFSET_BITS = mem_arb_pkg::OFFSET_BITS,
    parameter int PERF_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ic_miss_req,
    input  logic [ADDR_W-1:0]  ic_miss_addr,
    output logic               ic_repair_resolved,
    output logic [BLOCK_W-1:0] ic_fill_data,
    input  logic               dc_miss_req,
    input  logic [ADDR_W-1:0]  dc_miss_addr,
    output logic               dc_repair_resolved,
    output logic [BLOCK_W-1:0] dc_fill_data,
    input  logic               dc_wb_req,
    input  logic [ADDR_W-1:0]  dc_wb_addr,
    input  logic [BLOCK_W-1:0] dc_wb_data,
    output logic               dc_wb_done,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_we,
    output logic [ADDR_W-1:0]  mem_req_addr,
    output logic [BLOCK_W-1:0] mem_req_wdata,
    input  logic               mem_resp_valid,
    input  logic [BLOCK_W-1:0] mem_resp_rdata,
    output logic [PERF_W-1:0]  perf_ic_refills,
    output logic [PERF_W-1:0]  perf_dc_refills,
    output logic [PERF_W-1:0]  perf_wbs,
    output logic [PERF_W-1:0]  perf_busy_cycles
);

    import mem_arb_pkg::*;

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    arb_src_e           r_src;
    arb_src_e           w_src;
    logic               r_rr;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_sel;
    logic [BLOCK_W-1:0] r_wdata;
    logic [BLOCK_W-1:0] r_ic_fill;
    logic [BLOCK_W-1:0] r_dc_fill;
    logic [1:0]         w_gnt;
    logic               w_any_req;

    // r_rr = 1 gives the D-cache refill the tie, 0 gives it to the I-cache
    rr_pick2 u_rr_pick2 (
        .i_req (w_gnt_req_s()),
        .i_ptr (r_rr),
        .o_gnt (w_gnt)
    );

    function automatic logic [1:0] w_gnt_req_s();
        return {dc_miss_req, ic_miss_req};
    endfunction

    assign w_any_req = dc_wb_req | ic_miss_req | dc_miss_req;

    // grant decode: writeback first, then the round-robin winner
    always_comb begin
        w_src      = SRC_IC;
        w_addr_sel = ic_miss_addr;
        if (dc_wb_req) begin
            w_src      = SRC_WB;
            w_addr_sel = dc_wb_addr;
        end else if (w_gnt[1]) begin
            w_src      = SRC_DC;
            w_addr_sel = dc_miss_addr;
        end else begin
            w_src      = SRC_IC;
            w_addr_sel = ic_miss_addr;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_any_req ? ISSUE : IDLE;
            ISSUE:   w_state_nxt = mem_req_ready ? WAIT : ISSUE;
            WAIT:    w_state_nxt = mem_resp_valid ? DONE : WAIT;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // state register plus the request latched at grant time
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_src   <= SRC_IC;
            r_rr    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= {ADDR_W{1'b0}};
            r_wdata <= {BLOCK_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any_req) begin
                r_src   <= w_src;
                r_we    <= dc_wb_req;
                r_addr  <= {w_addr_sel[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                r_wdata <= dc_wb_req ? dc_wb_data : {BLOCK_W{1'b0}};
                if (!dc_wb_req) begin
                    r_rr <= w_gnt[0];
                end
            end
        end
    end

    // fill registers capture read data only in WAIT, so stray responses are dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ic_fill <= {BLOCK_W{1'b0}};
            r_dc_fill <= {BLOCK_W{1'b0}};
        end else if (r_state == WAIT && mem_resp_valid && !r_we) begin
            if (r_src == SRC_IC) begin
                r_ic_fill <= mem_resp_rdata;
            end else begin
                r_dc_fill <= mem_resp_rdata;
            end
        end
    end

    assign mem_req_valid      = (r_state == ISSUE);
    assign mem_req_we         = r_we;
    assign mem_req_addr       = r_addr;
    assign mem_req_wdata      = r_wdata;
    assign ic_fill_data       = r_ic_fill;
    assign dc_fill_data       = r_dc_fill;
    assign ic_repair_resolved = (r_state == DONE) && (r_src == SRC_IC);
    assign dc_repair_resolved = (r_state == DONE) && (r_src == SRC_DC);
    assign dc_wb_done         = (r_state == DONE) && (r_src == SRC_WB);

`ifdef ARB_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] r_perf_ic;
    logic [PERF_W-1:0] r_perf_dc;
    logic [PERF_W-1:0] r_perf_wb;
    logic [PERF_W-1:0] r_perf_busy;

    // saturating event and occupancy counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_ic   <= {PERF_W{1'b0}};
            r_perf_dc   <= {PERF_W{1'b0}};
            r_perf_wb   <= {PERF_W{1'b0}};
            r_perf_busy <= {PERF_W{1'b0}};
        end else begin
            if (ic_repair_resolved && r_perf_ic != PERF_MAX) r_perf_ic <= r_perf_ic + PERF_ONE;
            if (dc_repair_resolved && r_perf_dc != PERF_MAX) r_perf_dc <= r_perf_dc + PERF_ONE;
            if (dc_wb_done && r_perf_wb != PERF_MAX)         r_perf_wb <= r_perf_wb + PERF_ONE;
            if (r_state != IDLE && r_perf_busy != PERF_MAX)  r_perf_busy <= r_perf_busy + PERF_ONE;
        end
    end

    assign perf_ic_refills  = r_perf_ic;
    assign perf_dc_refills  = r_perf_dc;
    assign perf_wbs         = r_perf_wb;
    assign perf_busy_cycles = r_perf_busy;
`else
    assign perf_ic_refills  = {PERF_W{1'b0}};
    assign perf_dc_refills  = {PERF_W{1'b0}};
    assign perf_wbs         = {PERF_W{1'b0}};
    assign perf_busy_cycles = {PERF_W{1'b0}};
`endif

endmodule
